// File: rtl/tmr8_count_unit_if.sv
// Signal bundle between the timer count unit and its surroundings
// (prescaler tick, CPU register writes, waveform/event outputs).
// master: drives the tick/config/CPU-write side, observes outputs.
// slave : the count unit itself.
interface tmr8_count_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clk_en;
    logic [2:0]       wgm;
    logic [1:0]       com_a;
    logic [1:0]       com_b;
    logic             tcnt_we;
    logic             ocra_we;
    logic             ocrb_we;
    logic [WIDTH-1:0] wdata;
    logic             foc_a;
    logic             foc_b;
    logic [WIDTH-1:0] tcnt;
    logic [WIDTH-1:0] ocra;
    logic [WIDTH-1:0] ocrb;
    logic             oc_a;
    logic             oc_b;
    logic             oc_a_en;
    logic             oc_b_en;
    logic             tov_p;
    logic             ocfa_p;
    logic             ocfb_p;

    modport master (
        output clk_en, wgm, com_a, com_b, tcnt_we, ocra_we, ocrb_we, wdata, foc_a, foc_b,
        input  tcnt, ocra, ocrb, oc_a, oc_b, oc_a_en, oc_b_en, tov_p, ocfa_p, ocfb_p
    );

    modport slave (
        input  clk_en, wgm, com_a, com_b, tcnt_we, ocra_we, ocrb_we, wdata, foc_a, foc_b,
        output tcnt, ocra, ocrb, oc_a, oc_b, oc_a_en, oc_b_en, tov_p, ocfa_p, ocfb_p
    );
endinterface

// File: rtl/tmr8_count_unit.sv
// AVR-style 8-bit timer/counter core: counting (normal, CTC, fast PWM,
// phase-correct PWM), double-buffered compare registers, waveform
// generation and single-cycle overflow/compare event pulses.
// Ports:
//   clk  - system clock (prescaler tick is synchronous to it)
//   nrst - asynchronous active-low reset
//   bus  - tmr8_count_unit_if.slave: clk_en tick, wgm/com config, CPU
//          writes (tcnt/ocra/ocrb, foc), count, active compare values,
//          oc_x waveforms + pin enables, tov/ocfa/ocfb pulses
module tmr8_count_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    tmr8_count_unit_if.slave     bus
);
    localparam logic [WIDTH-1:0] TOP_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [2:0] {
        MODE_NORMAL,
        MODE_PC,
        MODE_CTC,
        MODE_FAST_MAX,
        MODE_FAST_OCRA
    } mode_t;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [WIDTH-1:0] tcnt_q, tcnt_n;
    logic [WIDTH-1:0] ocra_q, ocra_n, ocrb_q, ocrb_n;
    logic [WIDTH-1:0] ocra_buf_q, ocra_buf_n, ocrb_buf_q, ocrb_buf_n;
    logic             oc_a_q, oc_a_n, oc_b_q, oc_b_n;
    logic             tov_q, tov_n, ocfa_q, ocfa_n, ocfb_q, ocfb_n;
    logic             block_q, block_n;
    dir_t             dir_q, dir_n;

    mode_t            mode;
    logic             is_pwm, is_fast, tick, at_top, load_buf, wrap;
    logic             match_a, match_b;
    logic [WIDTH-1:0] top;

    always_comb begin
        unique case (bus.wgm)
            3'b001:  mode = MODE_PC;
            3'b010:  mode = MODE_CTC;
            3'b011:  mode = MODE_FAST_MAX;
            3'b111:  mode = MODE_FAST_OCRA;
            default: mode = MODE_NORMAL;
        endcase
    end

    // Next waveform level for one channel. Non-PWM modes share one action
    // for match and force, so a coincident foc+match acts only once.
    function automatic logic wave_next(input mode_t m, input dir_t d,
                                       input logic [1:0] com, input logic cur,
                                       input logic hit, input logic frc,
                                       input logic wrp, input logic tgl_ok);
        logic nxt;
        nxt = cur;
        unique case (m)
            MODE_FAST_MAX, MODE_FAST_OCRA: begin
                unique case (com)
                    2'b01:   if (hit && tgl_ok) nxt = ~cur;
                    2'b10:   if (hit) nxt = 1'b0; else if (wrp) nxt = 1'b1;
                    2'b11:   if (hit) nxt = 1'b1; else if (wrp) nxt = 1'b0;
                    default: nxt = cur;
                endcase
            end
            MODE_PC: begin
                if (hit) begin
                    if (com == 2'b10)      nxt = (d == DIR_DOWN);
                    else if (com == 2'b11) nxt = (d == DIR_UP);
                end
            end
            default: begin
                if (hit || frc) begin
                    unique case (com)
                        2'b01:   nxt = ~cur;
                        2'b10:   nxt = 1'b0;
                        2'b11:   nxt = 1'b1;
                        default: nxt = cur;
                    endcase
                end
            end
        endcase
        return nxt;
    endfunction

    always_comb begin
        is_pwm  = (mode == MODE_PC) || (mode == MODE_FAST_MAX) || (mode == MODE_FAST_OCRA);
        is_fast = (mode == MODE_FAST_MAX) || (mode == MODE_FAST_OCRA);
        tick    = bus.clk_en;
        top     = (mode == MODE_FAST_OCRA) ? ocra_q : TOP_MAX;
        at_top  = (tcnt_q == top);
        wrap    = tick && is_fast && at_top;
        match_a = tick && !block_q && (tcnt_q == ocra_q);
        match_b = tick && !block_q && (tcnt_q == ocrb_q);

        tcnt_n   = tcnt_q;
        dir_n    = dir_q;
        tov_n    = 1'b0;
        load_buf = 1'b0;

        if (tick) begin
            unique case (mode)
                MODE_CTC: begin
                    tcnt_n = (tcnt_q == ocra_q) ? '0 : tcnt_q + ONE;
                    tov_n  = (tcnt_q == TOP_MAX);
                end
                MODE_FAST_MAX, MODE_FAST_OCRA: begin
                    tcnt_n   = at_top ? '0 : tcnt_q + ONE;
                    tov_n    = at_top;
                    load_buf = at_top;
                end
                MODE_PC: begin
                    if (dir_q == DIR_UP) begin
                        if (tcnt_q == TOP_MAX) begin
                            tcnt_n   = TOP_MAX - ONE;
                            dir_n    = DIR_DOWN;
                            load_buf = 1'b1;
                        end else begin
                            tcnt_n = tcnt_q + ONE;
                        end
                    end else begin
                        if (tcnt_q == '0) begin
                            tcnt_n = ONE;
                            dir_n  = DIR_UP;
                            tov_n  = 1'b1;
                        end else begin
                            tcnt_n = tcnt_q - ONE;
                        end
                    end
                end
                default: begin
                    tcnt_n = tcnt_q + ONE;
                    tov_n  = (tcnt_q == TOP_MAX);
                end
            endcase
        end

        if (mode != MODE_PC) dir_n = DIR_UP;
        // CPU write replaces the count but leaves the direction decision intact.
        if (bus.tcnt_we) tcnt_n = bus.wdata;

        if (bus.tcnt_we)  block_n = 1'b1;
        else if (tick)    block_n = 1'b0;
        else              block_n = block_q;

        ocra_buf_n = bus.ocra_we ? bus.wdata : ocra_buf_q;
        ocrb_buf_n = bus.ocrb_we ? bus.wdata : ocrb_buf_q;
        ocra_n = ocra_q;
        ocrb_n = ocrb_q;
        if (!is_pwm && bus.ocra_we) ocra_n = bus.wdata;
        else if (load_buf)          ocra_n = ocra_buf_q;
        if (!is_pwm && bus.ocrb_we) ocrb_n = bus.wdata;
        else if (load_buf)          ocrb_n = ocrb_buf_q;

        oc_a_n = wave_next(mode, dir_q, bus.com_a, oc_a_q, match_a,
                           bus.foc_a && !is_pwm, wrap, mode == MODE_FAST_OCRA);
        oc_b_n = wave_next(mode, dir_q, bus.com_b, oc_b_q, match_b,
                           bus.foc_b && !is_pwm, wrap, 1'b0);
        ocfa_n = match_a;
        ocfb_n = match_b;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tcnt_q     <= '0;
            ocra_q     <= '0;
            ocrb_q     <= '0;
            ocra_buf_q <= '0;
            ocrb_buf_q <= '0;
            oc_a_q     <= 1'b0;
            oc_b_q     <= 1'b0;
            tov_q      <= 1'b0;
            ocfa_q     <= 1'b0;
            ocfb_q     <= 1'b0;
            block_q    <= 1'b0;
            dir_q      <= DIR_UP;
        end else begin
            tcnt_q     <= tcnt_n;
            ocra_q     <= ocra_n;
            ocrb_q     <= ocrb_n;
            ocra_buf_q <= ocra_buf_n;
            ocrb_buf_q <= ocrb_buf_n;
            oc_a_q     <= oc_a_n;
            oc_b_q     <= oc_b_n;
            tov_q      <= tov_n;
            ocfa_q     <= ocfa_n;
            ocfb_q     <= ocfb_n;
            block_q    <= block_n;
            dir_q      <= dir_n;
        end
    end

    assign bus.tcnt    = tcnt_q;
    assign bus.ocra    = ocra_q;
    assign bus.ocrb    = ocrb_q;
    assign bus.oc_a    = oc_a_q;
    assign bus.oc_b    = oc_b_q;
    assign bus.oc_a_en = |bus.com_a;
    assign bus.oc_b_en = |bus.com_b;
    assign bus.tov_p   = tov_q;
    assign bus.ocfa_p  = ocfa_q;
    assign bus.ocfb_p  = ocfb_q;
endmodule

// File: tb/tb_tmr8_count_unit.sv
// Directed self-checking bench for tmr8_count_unit.
module tb_tmr8_count_unit;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;
    int   tov_cnt;
    int   ocfa_cnt;
    int   ocfb_cnt;
    int   tov_edge;

    tmr8_count_unit_if #(.WIDTH(8)) bus ();

    tmr8_count_unit #(.WIDTH(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_counts();
        tov_cnt  = 0;
        ocfa_cnt = 0;
        ocfb_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.tov_p)  tov_cnt++;
        if (bus.ocfa_p) ocfa_cnt++;
        if (bus.ocfb_p) ocfb_cnt++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.clk_en = 1'b1;
            step();
        end
        bus.clk_en = 1'b0;
    endtask

    task automatic do_reset();
        bus.clk_en  = 1'b0;
        bus.wgm     = 3'b000;
        bus.com_a   = 2'b00;
        bus.com_b   = 2'b00;
        bus.tcnt_we = 1'b0;
        bus.ocra_we = 1'b0;
        bus.ocrb_we = 1'b0;
        bus.wdata   = '0;
        bus.foc_a   = 1'b0;
        bus.foc_b   = 1'b0;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        clear_counts();
    endtask

    // which: 0 = tcnt, 1 = ocra, 2 = ocrb
    task automatic cpu_write(input int which, input logic [7:0] data);
        bus.wdata   = data;
        bus.tcnt_we = (which == 0);
        bus.ocra_we = (which == 1);
        bus.ocrb_we = (which == 2);
        step();
        bus.tcnt_we = 1'b0;
        bus.ocra_we = 1'b0;
        bus.ocrb_we = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_tcnt", bus.tcnt, 0);
        check_eq("rst_ocra", bus.ocra, 0);
        check_eq("rst_ocrb", bus.ocrb, 0);
        check_eq("rst_oc_a", bus.oc_a, 0);
        check_eq("rst_oc_b", bus.oc_b, 0);
        check_eq("rst_tov",  bus.tov_p, 0);
        check_eq("rst_oc_a_en", bus.oc_a_en, 0);

        // Normal mode, tick every 8th cycle
        tov_edge = 0;
        for (int e = 1; e <= 2048; e++) begin
            bus.clk_en = ((e % 8) == 0);
            step();
            if (bus.tov_p) tov_edge = e;
            if (e == 1024) check_eq("norm_mid_tcnt", bus.tcnt, 8'h80);
            if (e == 2040) check_eq("norm_ff_tcnt", bus.tcnt, 8'hFF);
        end
        bus.clk_en = 1'b0;
        check_eq("norm_tov_cnt", tov_cnt, 1);
        check_eq("norm_tov_edge", tov_edge, 2048);
        check_eq("norm_wrap_tcnt", bus.tcnt, 0);

        // CTC, OCRA=09, toggle
        do_reset();
        bus.wgm   = 3'b010;
        bus.com_a = 2'b01;
        cpu_write(1, 8'h09);
        check_eq("ctc_ocra_direct", bus.ocra, 8'h09);
        check_eq("ctc_oc_a_en", bus.oc_a_en, 1);
        run_ticks(10);
        check_eq("ctc_first_ocfa", bus.ocfa_p, 1);
        check_eq("ctc_first_oc_a", bus.oc_a, 1);
        check_eq("ctc_first_tcnt", bus.tcnt, 0);
        run_ticks(9);
        check_eq("ctc_hold_oc_a", bus.oc_a, 1);
        check_eq("ctc_hold_ocfa_cnt", ocfa_cnt, 1);
        run_ticks(1);
        check_eq("ctc_second_oc_a", bus.oc_a, 0);
        check_eq("ctc_second_ocfa", bus.ocfa_p, 1);
        run_ticks(40);
        check_eq("ctc_ocfa_cnt", ocfa_cnt, 6);
        check_eq("ctc_tov_cnt", tov_cnt, 0);
        check_eq("ctc_end_oc_a", bus.oc_a, 0);

        // Fast PWM TOP=FF, OCRB=3F, clear on match / set at bottom
        do_reset();
        cpu_write(2, 8'h3F);
        bus.wgm   = 3'b011;
        bus.com_b = 2'b10;
        run_ticks(256);
        check_eq("fpwm_wrap_tov", bus.tov_p, 1);
        check_eq("fpwm_wrap_tcnt", bus.tcnt, 0);
        check_eq("fpwm_wrap_oc_b", bus.oc_b, 1);
        check_eq("fpwm_tov_cnt", tov_cnt, 1);
        run_ticks(63);
        check_eq("fpwm_3f_oc_b", bus.oc_b, 1);
        run_ticks(1);
        check_eq("fpwm_40_tcnt", bus.tcnt, 8'h40);
        check_eq("fpwm_40_oc_b", bus.oc_b, 0);
        check_eq("fpwm_40_ocfb", bus.ocfb_p, 1);
        cpu_write(2, 8'h80);
        check_eq("fpwm_buffered_ocrb", bus.ocrb, 8'h3F);
        run_ticks(192);
        check_eq("fpwm_load_tcnt", bus.tcnt, 0);
        check_eq("fpwm_load_ocrb", bus.ocrb, 8'h80);
        check_eq("fpwm_load_oc_b", bus.oc_b, 1);
        run_ticks(65);
        check_eq("fpwm_41_oc_b", bus.oc_b, 1);
        run_ticks(64);
        check_eq("fpwm_81_tcnt", bus.tcnt, 8'h81);
        check_eq("fpwm_81_oc_b", bus.oc_b, 0);

        // Phase-correct, OCRA=40, com_a=10
        do_reset();
        cpu_write(1, 8'h40);
        bus.wgm   = 3'b001;
        bus.com_a = 2'b10;
        run_ticks(255);
        check_eq("pc_top_tcnt", bus.tcnt, 8'hFF);
        run_ticks(1);
        check_eq("pc_turn_tcnt", bus.tcnt, 8'hFE);
        run_ticks(190);
        check_eq("pc_down40_tcnt", bus.tcnt, 8'h40);
        check_eq("pc_down40_oc_a", bus.oc_a, 0);
        run_ticks(1);
        check_eq("pc_dmatch_tcnt", bus.tcnt, 8'h3F);
        check_eq("pc_dmatch_oc_a", bus.oc_a, 1);
        check_eq("pc_dmatch_ocfa", bus.ocfa_p, 1);
        run_ticks(63);
        check_eq("pc_bottom_tcnt", bus.tcnt, 0);
        check_eq("pc_no_tov_yet", tov_cnt, 0);
        run_ticks(1);
        check_eq("pc_turn_tov", bus.tov_p, 1);
        check_eq("pc_turn_up_tcnt", bus.tcnt, 1);
        check_eq("pc_tov_cnt", tov_cnt, 1);
        run_ticks(63);
        check_eq("pc_up40_oc_a", bus.oc_a, 1);
        run_ticks(1);
        check_eq("pc_umatch_tcnt", bus.tcnt, 8'h41);
        check_eq("pc_umatch_oc_a", bus.oc_a, 0);

        // CTC: tcnt write blocks next match; force output compare
        do_reset();
        bus.wgm = 3'b010;
        cpu_write(1, 8'h09);
        run_ticks(3);
        check_eq("blk_tcnt3", bus.tcnt, 3);
        cpu_write(0, 8'h09);
        check_eq("blk_write_tcnt", bus.tcnt, 9);
        clear_counts();
        run_ticks(1);
        check_eq("blk_no_ocfa", bus.ocfa_p, 0);
        check_eq("blk_clear_tcnt", bus.tcnt, 0);
        run_ticks(9);
        check_eq("blk_ocfa_cnt", ocfa_cnt, 0);
        run_ticks(1);
        check_eq("blk_next_ocfa", bus.ocfa_p, 1);
        bus.com_a = 2'b11;
        bus.foc_a = 1'b1;
        step();
        bus.foc_a = 1'b0;
        check_eq("foc_oc_a", bus.oc_a, 1);
        check_eq("foc_no_ocfa", bus.ocfa_p, 0);
        check_eq("foc_tcnt", bus.tcnt, 0);
        bus.com_a = 2'b01;
        run_ticks(9);
        check_eq("foc_pre_tcnt", bus.tcnt, 9);
        bus.clk_en = 1'b1;
        bus.foc_a  = 1'b1;
        step();
        bus.clk_en = 1'b0;
        bus.foc_a  = 1'b0;
        check_eq("foc_match_single_toggle", bus.oc_a, 0);
        check_eq("foc_match_ocfa", bus.ocfa_p, 1);

        // Asynchronous reset mid-count in phase-correct down phase
        do_reset();
        bus.com_a = 2'b11;
        bus.com_b = 2'b11;
        bus.foc_a = 1'b1;
        bus.foc_b = 1'b1;
        step();
        bus.foc_a = 1'b0;
        bus.foc_b = 1'b0;
        bus.com_a = 2'b00;
        bus.com_b = 2'b00;
        bus.wgm   = 3'b001;
        run_ticks(345);
        check_eq("arst_pre_tcnt", bus.tcnt, 8'hA5);
        check_eq("arst_pre_oc_a", bus.oc_a, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_eq("arst_tcnt", bus.tcnt, 0);
        check_eq("arst_oc_a", bus.oc_a, 0);
        check_eq("arst_oc_b", bus.oc_b, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        run_ticks(1);
        check_eq("arst_dir_up", bus.tcnt, 1);
        run_ticks(1);
        check_eq("arst_dir_up2", bus.tcnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tmr8_count_unit.md
Name: tmr8_count_unit

Overview:
- 8-bit timer/counter core that consumes the `clk_en` tick produced by the timer prescaler.
- Implements counting, waveform generation and compare-match/overflow event generation for an AVR-style 8-bit timer.
- Sits between the prescaler and the timer register/interrupt-flag block.
- Events are single-cycle pulses; flag latching and interrupt masking are done downstream.

Parameters:
- WIDTH, 8, counter and compare register width; TOP_MAX is all ones.

Ports:
- clk  in  1  system clock, same clock the prescaler output is synchronous to
- nrst  in  1  asynchronous active-low reset
- clk_en  in  1  count tick from the prescaler; the counter advances only on cycles where it is high
- wgm  in  3  waveform mode: 000 normal, 001 phase-correct PWM (TOP=FF), 010 CTC (TOP=OCRA), 011 fast PWM (TOP=FF), 111 fast PWM (TOP=OCRA); other codes behave as normal
- com_a, com_b  in  2  compare output mode for channel A/B
- tcnt_we  in  1  CPU write strobe for the counter
- ocra_we, ocrb_we  in  1  CPU write strobes for the compare buffers
- wdata  in  WIDTH  CPU write data
- foc_a, foc_b  in  1  force output compare strobes
- tcnt  out  WIDTH  current count
- ocra, ocrb  out  WIDTH  active (in-use) compare values
- oc_a, oc_b  out  1  waveform outputs
- oc_a_en, oc_b_en  out  1  pin override enable: high when com_x != 00
- tov_p, ocfa_p, ocfb_p  out  1  one-cycle event pulses

Behaviour:
- Reset (nrst low, asynchronous):
  - tcnt, ocra/ocrb, both buffers, oc_a, oc_b and all pulses are 0.
  - Direction is up.
  - Effective mid-operation; counting resumes from 0 on the first clk_en after release.
- Counter:
  - All events evaluate the pre-edge tcnt on a clk_en=1 cycle; results are registered at that edge.
  - Pulses are high for exactly one clk cycle after that edge.
  - With clk_en=0 nothing changes except CPU writes.
- Normal: tcnt increments; FF->00 gives tov_p.
- CTC:
  - tcnt==OCRA -> next value 00 (OCRA=00 holds the counter at 0).
  - tov_p only on the FF->00 wrap, which happens when OCRA is lowered below tcnt.
- Fast PWM: count to TOP, then 00; tov_p on the TOP->00 edge.
- Phase-correct:
  - Count up to FF, then down (FF->FE); count down to 00, then up (00->01).
  - tov_p on the 00->01 turn.
- Compare match: tcnt==ocrx on a tick gives ocfx_p.
  - A match is blocked on the first tick following a tcnt_we.
  - Non-PWM output action per com: 01 toggle, 10 clear, 11 set.
  - Fast PWM, com 10: clear on match, set on the TOP->00 edge; 11 is the inverse. Match wins if OCR==TOP.
  - Phase-correct, com 10: clear on up-count match, set on down-count match; 11 is the inverse.
  - PWM com 01: oc_a toggles on match only in mode 111; otherwise oc_x holds.
- OCR buffering:
  - Normal/CTC: a write updates the active ocrx in the same edge.
  - Fast PWM: the buffer loads into active at the TOP->00 edge.
  - Phase-correct: the buffer loads at the FF->FE turn.
- CPU tcnt write:
  - Overrides the increment in the same edge.
  - A direction change is not caused by the write.
- foc_x: in non-PWM modes, applies the com action at the next edge without ocfx_p and without clearing tcnt; ignored in PWM modes.
- Simultaneous foc and match on the same edge: the result equals a single action, with no double toggle.
- Mode change while counting takes effect at the next tick; direction is forced up when leaving phase-correct.

Test Plan:
- Normal, clk_en every 8 cycles, from reset -> tcnt 00..FF, tov_p pulses once at the 256th tick (cycle 2048), then tcnt=00.
- CTC, OCRA=09, com_a=01, clk_en=1 -> period 10 ticks, ocfa_p every 10 cycles, oc_a toggles each match (20-cycle period), tov_p never.
- Fast PWM FF, OCRB=3F, com_b=10 -> oc_b high for ticks 00..3F, low 40..FF; OCRB write of 80 mid-period applies only after the next 00.
- Phase-correct, OCRA=40, com_a=10 -> period 510 ticks; oc_a low from up-match 40 to down-match 40; tov_p at 00 turn only.
- tcnt_we with wdata=OCRA in CTC -> no ocfa_p on the next tick; match occurs a full period later. foc_a in CTC with com_a=11 -> oc_a=1, no ocfa_p.
- Assert nrst mid-count at tcnt=A5 without a clock edge -> tcnt, oc_a and oc_b are 0 immediately; direction is up after release.
